// File: rtl/inst_loader.sv
// Byte-stream program loader: frames of header N + N big-endian 16-bit words into icmem, core held in reset until done.
// Write strobe one cycle after the low byte; core released two edges after the last byte; in_ready depends on state only.
module inst_loader #(
    parameter int ISA_WIDTH  = 16,
    parameter int BYTE_WIDTH = 8,
    parameter int MAX_INSTS  = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BYTE_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  inst_wen,
    output logic [ISA_WIDTH-1:0]  input_inst,
    output logic [CNT_WIDTH-1:0]  inst_cnt,
    output logic                  core_rst,
    output logic                  load_done,
    output logic                  load_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_HI,
        S_LO,
        S_FIN,
        S_RUN,
        S_ERR
    } state_t;

    localparam int HW = BYTE_WIDTH + CNT_WIDTH;
    localparam logic [HW-1:0] HDR_MAX = HW'(MAX_INSTS);

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   n_q, n_d;
    logic [BYTE_WIDTH-1:0]  hi_q, hi_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [ISA_WIDTH-1:0]   inst_q, inst_d;
    logic                   wen_q, wen_d;
    logic                   core_rst_q, core_rst_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic                   accept;
    logic                   arm;
    logic                   hdr_bad;
    logic [CNT_WIDTH-1:0]   cnt_inc;
    logic                   last_word;

    assign accept    = in_valid & in_ready;
    assign arm       = start & ((state_q == S_IDLE) | (state_q == S_RUN) | (state_q == S_ERR));
    assign hdr_bad   = (in_data == '0) || ({{CNT_WIDTH{1'b0}}, in_data} > HDR_MAX);
    assign cnt_inc   = cnt_q + 1'b1;
    assign last_word = (cnt_inc == n_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_RUN, S_ERR: if (arm) state_d = S_HDR;
            S_HDR:  if (accept) state_d = hdr_bad ? S_ERR : S_HI;
            S_HI:   if (accept) state_d = S_LO;
            S_LO:   if (accept) state_d = last_word ? S_FIN : S_HI;
            S_FIN:  state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs trail the state by one edge, so FIN keeps the core in
    // reset through the final write strobe.
    always_comb begin
        in_ready   = (state_q == S_HDR) | (state_q == S_HI) | (state_q == S_LO);
        n_d        = n_q;
        hi_d       = hi_q;
        cnt_d      = cnt_q;
        inst_d     = inst_q;
        wen_d      = 1'b0;
        core_rst_d = (state_q != S_RUN);
        done_d     = (state_q == S_RUN);
        err_d      = (state_q == S_ERR);
        if (arm) begin
            cnt_d = '0;
        end
        if (accept) begin
            case (state_q)
                S_HDR: n_d = CNT_WIDTH'(in_data);
                S_HI:  hi_d = in_data;
                S_LO: begin
                    inst_d = {hi_q, in_data};
                    wen_d  = 1'b1;
                    cnt_d  = cnt_inc;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_q        <= '0;
            hi_q       <= '0;
            cnt_q      <= '0;
            inst_q     <= '0;
            wen_q      <= 1'b0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            n_q        <= n_d;
            hi_q       <= hi_d;
            cnt_q      <= cnt_d;
            inst_q     <= inst_d;
            wen_q      <= wen_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign inst_wen   = wen_q;
    assign input_inst = inst_q;
    assign inst_cnt   = cnt_q;
    assign core_rst   = core_rst_q;
    assign load_done  = done_q;
    assign load_err   = err_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: frame-position reference model checked every cycle, plus literal expectations.
module tb_inst_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        inst_wen;
    logic [15:0] input_inst;
    logic [5:0]  inst_cnt;
    logic        core_rst;
    logic        load_done;
    logic        load_err;

    inst_loader #(
        .ISA_WIDTH (16),
        .BYTE_WIDTH(8),
        .MAX_INSTS (32),
        .CNT_WIDTH (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inst_wen  (inst_wen),
        .input_inst(input_inst),
        .inst_cnt  (inst_cnt),
        .core_rst  (core_rst),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    bit          chk_en = 1'b0;
    logic [15:0] wr_q[$];
    logic [7:0]  frame_a[5] = '{8'h02, 8'h12, 8'h34, 8'h56, 8'h78};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks position within the frame rather than FSM states.
    localparam int M_IDLE = 0, M_LOAD = 1, M_FIN = 2, M_RUN = 3, M_ERR = 4;
    int          m_mode = M_IDLE;
    int          m_pos = 0;
    int          m_n = 0;
    int          m_cnt = 0;
    int          m_prev;
    logic [7:0]  m_hi = 8'h00;
    logic [15:0] m_inst = 16'h0000;
    bit          m_wen = 1'b0;
    bit          m_core_rst = 1'b1;
    bit          m_done = 1'b0;
    bit          m_err = 1'b0;

    always @(posedge clk) begin
        m_prev = m_mode;
        m_wen  = 1'b0;
        if (rst) begin
            m_mode = M_IDLE; m_pos = 0; m_cnt = 0; m_inst = 16'h0000;
            m_core_rst = 1'b1; m_done = 1'b0; m_err = 1'b0;
        end else begin
            if (m_mode == M_LOAD && in_valid) begin
                if (m_pos == 0) begin
                    m_n = int'(in_data);
                    if (m_n == 0 || m_n > 32) m_mode = M_ERR;
                end else if (m_pos % 2 == 1) begin
                    m_hi = in_data;
                end else begin
                    m_inst = {m_hi, in_data};
                    m_wen  = 1'b1;
                    m_cnt  = m_cnt + 1;
                    if (m_cnt == m_n) m_mode = M_FIN;
                end
                m_pos = m_pos + 1;
            end else if (m_mode == M_FIN) begin
                m_mode = M_RUN;
            end else if (m_mode != M_LOAD && start) begin
                m_mode = M_LOAD; m_pos = 0; m_cnt = 0;
            end
            m_core_rst = (m_prev != M_RUN);
            m_done     = (m_prev == M_RUN);
            m_err      = (m_prev == M_ERR);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, m_mode == M_LOAD});
            chk("inst_wen", {31'd0, inst_wen}, {31'd0, m_wen});
            if (m_wen) chk("input_inst", {16'd0, input_inst}, {16'd0, m_inst});
            chk("inst_cnt", {26'd0, inst_cnt}, 32'(m_cnt));
            chk("core_rst", {31'd0, core_rst}, {31'd0, m_core_rst});
            chk("load_done", {31'd0, load_done}, {31'd0, m_done});
            chk("load_err", {31'd0, load_err}, {31'd0, m_err});
            if (inst_wen) wr_q.push_back(input_inst);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int tries;
        tries = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && tries < 16) begin
            step();
            tries++;
        end
        if (tries == 16) chk("hs_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        if (gap) step();
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        step();
        step();
        chk_en = 1'b1;
        chk("rst_core_rst", {31'd0, core_rst}, 32'd1);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_wen", {31'd0, inst_wen}, 32'd0);
        chk("rst_inst", {16'd0, input_inst}, 32'd0);
        chk("rst_cnt", {26'd0, inst_cnt}, 32'd0);
        chk("rst_done_err", {30'd0, load_done, load_err}, 32'd0);
        rst = 1'b0;
        step();

        // Basic frame, back to back, with release timing
        wr_q.delete();
        do_start();
        for (int i = 0; i < 5; i++) send_byte(frame_a[i], 1'b0);
        chk("a_wen_last", {31'd0, inst_wen}, 32'd1);
        chk("a_inst_last", {16'd0, input_inst}, 32'h5678);
        chk("a_core_rst_t1", {31'd0, core_rst}, 32'd1);
        step();
        chk("a_core_rst_t2", {31'd0, core_rst}, 32'd1);
        step();
        chk("a_core_rst_t3", {31'd0, core_rst}, 32'd0);
        chk("a_done", {31'd0, load_done}, 32'd1);
        chk("a_cnt", {26'd0, inst_cnt}, 32'd2);
        chk("a_nwr", 32'(wr_q.size()), 32'd2);
        if (wr_q.size() == 2) begin
            chk("a_wr0", {16'd0, wr_q[0]}, 32'h1234);
            chk("a_wr1", {16'd0, wr_q[1]}, 32'h5678);
        end

        // Same frame with in_valid toggled every other cycle
        wr_q.delete();
        do_start();
        for (int i = 0; i < 5; i++) send_byte(frame_a[i], 1'b1);
        step();
        chk("t_nwr", 32'(wr_q.size()), 32'd2);
        if (wr_q.size() == 2) begin
            chk("t_wr0", {16'd0, wr_q[0]}, 32'h1234);
            chk("t_wr1", {16'd0, wr_q[1]}, 32'h5678);
        end
        chk("t_done", {31'd0, load_done}, 32'd1);

        // Illegal headers
        wr_q.delete();
        do_start();
        send_byte(8'h00, 1'b0);
        step();
        chk("h0_err", {31'd0, load_err}, 32'd1);
        chk("h0_core_rst", {31'd0, core_rst}, 32'd1);
        do_start();
        step();
        chk("h33_err_clear", {31'd0, load_err}, 32'd0);
        send_byte(8'h21, 1'b0);
        step();
        step();
        chk("h33_err", {31'd0, load_err}, 32'd1);
        chk("h33_core_rst", {31'd0, core_rst}, 32'd1);
        chk("herr_nwr", 32'(wr_q.size()), 32'd0);

        // Full-depth program, then restart from RUN
        wr_q.delete();
        do_start();
        send_byte(8'h20, 1'b0);
        for (int i = 0; i < 32; i++) begin
            send_byte(8'(i), 1'b0);
            send_byte(~8'(i), 1'b0);
        end
        step();
        step();
        chk("f_nwr", 32'(wr_q.size()), 32'd32);
        if (wr_q.size() == 32) begin
            chk("f_wr0", {16'd0, wr_q[0]}, 32'h00FF);
            chk("f_wr31", {16'd0, wr_q[31]}, 32'h1FE0);
        end
        chk("f_cnt", {26'd0, inst_cnt}, 32'd32);
        chk("f_done", {31'd0, load_done}, 32'd1);
        do_start();
        step();
        chk("r_core_rst", {31'd0, core_rst}, 32'd1);
        chk("r_done", {31'd0, load_done}, 32'd0);
        chk("r_cnt", {26'd0, inst_cnt}, 32'd0);
        wr_q.delete();
        send_byte(8'h01, 1'b0);
        send_byte(8'hAB, 1'b0);
        send_byte(8'hCD, 1'b0);
        step();
        step();
        chk("r_nwr", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() == 1) chk("r_wr0", {16'd0, wr_q[0]}, 32'hABCD);
        chk("r_done2", {31'd0, load_done}, 32'd1);

        // Reset in the middle of a load
        wr_q.delete();
        do_start();
        send_byte(8'h03, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        rst = 1'b1;
        in_data = 8'h44;
        in_valid = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("m_nwr", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() == 1) chk("m_wr0", {16'd0, wr_q[0]}, 32'h1122);
        chk("m_core_rst", {31'd0, core_rst}, 32'd1);
        chk("m_in_ready", {31'd0, in_ready}, 32'd0);
        chk("m_cnt", {26'd0, inst_cnt}, 32'd0);
        in_valid = 1'b0;
        step();

        // start held high during HI/LO is ignored
        wr_q.delete();
        do_start();
        send_byte(frame_a[0], 1'b0);
        start = 1'b1;
        for (int i = 1; i < 4; i++) send_byte(frame_a[i], 1'b0);
        start = 1'b0;
        send_byte(frame_a[4], 1'b0);
        step();
        step();
        chk("s_nwr", 32'(wr_q.size()), 32'd2);
        if (wr_q.size() == 2) begin
            chk("s_wr0", {16'd0, wr_q[0]}, 32'h1234);
            chk("s_wr1", {16'd0, wr_q[1]}, 32'h5678);
        end
        chk("s_cnt", {26'd0, inst_cnt}, 32'd2);
        chk("s_done", {31'd0, load_done}, 32'd1);

        step();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
